// File: rtl/alif_pkg.sv
// Shared widths, config-register addresses and reset constants for the ALIF neuron.
package alif_pkg;

    localparam int V_W = 10;
    localparam int A_W = 8;
    localparam int I_W = 8;

    localparam logic [1:0] ADDR_THB  = 2'd0;
    localparam logic [1:0] ADDR_LS   = 2'd1;
    localparam logic [1:0] ADDR_AINC = 2'd2;
    localparam logic [1:0] ADDR_AS   = 2'd3;

    typedef struct packed {
        logic [7:0] thb;
        logic [2:0] leak_shift;
        logic [7:0] ainc;
        logic [2:0] adapt_shift;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        thb:         8'h40,
        leak_shift:  3'd4,
        ainc:        8'd16,
        adapt_shift: 3'd5
    };

endpackage

// File: rtl/alif_core.sv
// ALIF neuron state: leaky membrane V, adaptation A and a registered one-cycle spike.
module alif_core
    import alif_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           update,
    input  logic           clear,
    input  logic [I_W-1:0] cur,
    input  cfg_t           cfg,
    output logic [V_W-1:0] v,
    output logic           spike
);

    logic [A_W-1:0] a;
    logic [V_W-1:0] leaked;
    logic [V_W:0]   sum_raw;
    logic [V_W-1:0] sum_sat;
    logic [V_W:0]   thr;
    logic [A_W:0]   a_up;
    logic [A_W-1:0] a_inc_sat;
    logic [A_W-1:0] a_decay;
    logic           fire;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        leaked    = v - (v >> cfg.leak_shift);
        sum_raw   = {1'b0, leaked} + {{(V_W + 1 - I_W){1'b0}}, cur};
        sum_sat   = sum_raw[V_W] ? '1 : sum_raw[V_W-1:0];
        thr       = {1'b0, cfg.thb, 2'b00} + {{(V_W + 1 - A_W){1'b0}}, a};
        fire      = ({1'b0, sum_sat} >= thr);
        a_up      = {1'b0, a} + {1'b0, cfg.ainc};
        a_inc_sat = a_up[A_W] ? '1 : a_up[A_W-1:0];
        a_decay   = a - (a >> cfg.adapt_shift);
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            a     <= '0;
            spike <= 1'b0;
        end else if (clear) begin
            v     <= '0;
            a     <= '0;
            spike <= 1'b0;
        end else if (update) begin
            if (fire) begin
                v     <= '0;
                a     <= a_inc_sat;
                spike <= 1'b1;
            end else begin
                v     <= sum_sat;
                a     <= a_decay;
                spike <= 1'b0;
            end
        end else begin
            // Config writes and disabled cycles hold V/A but never extend a spike.
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/alif_single_channel.sv
// TinyTapeout wrapper: config register file, control decode and pin mapping around alif_core.
module alif_single_channel
    import alif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic           cfg_we;
    logic           soft_clear;
    logic [1:0]     cfg_addr;
    cfg_t           cfg;
    logic [V_W-1:0] v;
    logic           spike;
    logic           update;
    logic           clear;
    logic           unused_ok;

    assign cfg_we     = uio_in[7];
    assign soft_clear = uio_in[6];
    assign cfg_addr   = uio_in[1:0];

    // Priority: config write, then soft clear, then neuron update.
    assign clear  = ena && !cfg_we && soft_clear;
    assign update = ena && !cfg_we && !soft_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= CFG_RST;
        end else if (ena && cfg_we) begin
            case (cfg_addr)
                ADDR_THB:  cfg.thb         <= ui_in;
                ADDR_LS:   cfg.leak_shift  <= ui_in[2:0];
                ADDR_AINC: cfg.ainc        <= ui_in;
                ADDR_AS:   cfg.adapt_shift <= ui_in[2:0];
            endcase
        end
    end

    alif_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (update),
        .clear  (clear),
        .cur    (ui_in),
        .cfg    (cfg),
        .v      (v),
        .spike  (spike)
    );

    assign uo_out  = {spike, v[V_W-1:3]};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign unused_ok = &{1'b0, uio_in[5:2], v[2:0]};

endmodule

// File: tb/tb_alif_single_channel.sv
// Bench for alif_single_channel: directed vector table, hand-written corner sequences, random vs model.
module tb_alif_single_channel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    alif_single_channel dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_uo;
        string      name;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain integer arithmetic on the neuron rules.
    int m_v, m_a, m_spike, m_thb, m_ls, m_ainc, m_as;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%02h, want 0x%02h", name, actual, expected);
    endtask

    function automatic void model_reset();
        m_v = 0; m_a = 0; m_spike = 0;
        m_thb = 64; m_ls = 4; m_ainc = 16; m_as = 5;
    endfunction

    function automatic void model_step(input logic en, input logic [7:0] ui, input logic [7:0] uio);
        int sum, thr;
        if (!en) begin
            m_spike = 0;
        end else if (uio[7]) begin
            case (int'(uio[1:0]))
                0: m_thb  = int'(ui);
                1: m_ls   = int'(ui) % 8;
                2: m_ainc = int'(ui);
                default: m_as = int'(ui) % 8;
            endcase
            m_spike = 0;
        end else if (uio[6]) begin
            m_v = 0; m_a = 0; m_spike = 0;
        end else begin
            sum = m_v - m_v / (2 ** m_ls) + int'(ui);
            if (sum > 1023) sum = 1023;
            thr = m_thb * 4 + m_a;
            if (sum >= thr) begin
                m_spike = 1;
                m_v = 0;
                m_a = (m_a + m_ainc > 255) ? 255 : m_a + m_ainc;
            end else begin
                m_spike = 0;
                m_v = sum;
                m_a = m_a - m_a / (2 ** m_as);
            end
        end
    endfunction

    function automatic logic [7:0] model_uo();
        return 8'((m_spike * 128) + (m_v / 8));
    endfunction

    // Called at a negedge: drive, let one rising edge pass, return at the next negedge.
    task automatic step(input logic en, input logic [7:0] ui, input logic [7:0] uio);
        ena = en; ui_in = ui; uio_in = uio;
        @(posedge clk);
        model_step(en, ui, uio);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic void add(input logic en, input logic [7:0] ui, input logic [7:0] uio,
                                input logic [7:0] exp_uo, input string name);
        vec_t t;
        t.en = en; t.ui = ui; t.uio = uio; t.exp_uo = exp_uo; t.name = name;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [7:0] r_uio;
        logic       r_en;

        // LS=7 integration: V 100, 200, 299 crosses 256; second crossing at 272.
        add(1, 8'd7,   8'h81, 8'h00, "wr_ls7");
        add(1, 8'd100, 8'h00, 8'd12, "int_v100");
        add(1, 8'd100, 8'h00, 8'd25, "int_v200");
        add(1, 8'd100, 8'h00, 8'h80, "spike1");
        add(1, 8'd100, 8'h00, 8'd12, "post_spike_v100");
        add(1, 8'd100, 8'h00, 8'd25, "adapted_v200");
        add(1, 8'd100, 8'h00, 8'h80, "spike2_thr272");
        // Saturation: THB=0xFF, V 255, 509, 761, 1011, then 1023 reaches 1020.
        add(1, 8'd0,   8'h40, 8'h00, "soft_clear_a");
        add(1, 8'hFF,  8'h80, 8'h00, "wr_thb_ff");
        add(1, 8'd255, 8'h00, 8'd31,  "sat_v255");
        add(1, 8'd255, 8'h00, 8'd63,  "sat_v509");
        add(1, 8'd255, 8'h00, 8'd95,  "sat_v761");
        add(1, 8'd255, 8'h00, 8'd126, "sat_v1011");
        add(1, 8'd255, 8'h00, 8'h80,  "sat_spike");
        // Hold behaviour at V=200 across a config write and ena=0.
        add(1, 8'd0,   8'h40, 8'h00, "soft_clear_b");
        add(1, 8'd100, 8'h00, 8'd12, "hold_v100");
        add(1, 8'd100, 8'h00, 8'd25, "hold_v200");
        add(1, 8'd1,   8'h82, 8'd25, "cfg_write_holds_v");
        add(0, 8'd200, 8'h00, 8'd25, "ena0_hold1");
        add(0, 8'd200, 8'h00, 8'd25, "ena0_hold2");
        add(0, 8'd200, 8'h00, 8'd25, "ena0_hold3");
        add(1, 8'd255, 8'h00, 8'd56,  "resume_v454");
        add(1, 8'd255, 8'h00, 8'd88,  "resume_v706");
        add(1, 8'd255, 8'h00, 8'd119, "resume_v956");
        add(1, 8'd255, 8'h00, 8'h80,  "resume_spike");
        add(1, 8'd10,  8'h00, 8'd1,   "v10_a_nonzero");
        add(1, 8'd0,   8'h40, 8'h00,  "soft_clear_c");
        // Config survives soft clear: LS=7 leak gives 509 rather than 495.
        add(1, 8'd255, 8'h00, 8'd31,  "keep_v255");
        add(1, 8'd255, 8'h00, 8'd63,  "keep_ls7_v509");
        add(1, 8'd255, 8'h00, 8'd95,  "keep_v761");
        add(1, 8'd255, 8'h00, 8'd126, "keep_v1011");
        add(1, 8'd255, 8'h00, 8'h80,  "keep_spike");
        add(0, 8'd0,   8'h00, 8'h00,  "ena0_kills_spike");
        // thr=0: spike on every update cycle.
        add(1, 8'd0,   8'h40, 8'h00, "soft_clear_d");
        add(1, 8'd0,   8'h82, 8'h00, "wr_ainc0");
        add(1, 8'd0,   8'h80, 8'h00, "wr_thb0");
        add(1, 8'd5,   8'h00, 8'h80, "thr0_spike1");
        add(1, 8'd5,   8'h00, 8'h80, "thr0_spike2");
        add(1, 8'd5,   8'h00, 8'h80, "thr0_spike3");

        rst_n = 1'b0;
        #1;
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(1, 8'd0, 8'h00);
            check($sformatf("idle_%0d", i), uo_out, 8'h00);
        end

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].ui, tbl[i].uio);
            check(tbl[i].name, uo_out, tbl[i].exp_uo);
        end

        // Asynchronous reset lands mid-cycle while spiking; output clears before any edge.
        ena = 1'b1; ui_in = 8'd200; uio_in = 8'h00;
        @(posedge clk);
        #2;
        check("pre_async_rst_spike", uo_out, 8'h80);
        rst_n = 1'b0;
        #1;
        check("async_rst_immediate", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Default LS=4, THB=0x40: V 100, 194, 282 crosses 256.
        step(1, 8'd100, 8'h00);
        check("dflt_ls_v100", uo_out, 8'd12);
        step(1, 8'd100, 8'h00);
        check("dflt_ls_v194", uo_out, 8'd24);
        step(1, 8'd100, 8'h00);
        check("dflt_ls_spike", uo_out, 8'h80);

        // Random phase against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_uio = 8'($urandom_range(0, 255)) & 8'h3F;
            if ($urandom_range(0, 9) == 0) r_uio[7] = 1'b1;
            if ($urandom_range(0, 19) == 0) r_uio[6] = 1'b1;
            step(r_en, 8'($urandom_range(0, 255)), r_uio);
            check($sformatf("rand_%0d", i), uo_out, model_uo());
            if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                check($sformatf("rand_tieoff_%0d", i), uio_oe | uio_out, 8'h00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
